pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter and the two-phase FETCH/EXEC cycle state of the harvard CPU.
//  Sits directly downstream of branch_control:
//   - drives branch_control's state input
//   - consumes its registered jump_addr_selection
//   - applies the jump/branch after the branch delay slot has executed
//  Also provides the link value (PC+8) and the halt/active indication.
// PARAMETERS
//  RESET_VECTOR  32'hBFC0_0000  PC value loaded on reset
//  HALT_ADDR     32'h0000_0000  jump/branch to this address halts the CPU
// PORTS
//  clk                  in   1   system clock, rising-edge
//  reset_n              in   1   asynchronous, active-low reset
//  stall                in   1   instr/data memory wait; freezes all state while high
//  instruction_word     in   32  instruction of the current cycle (valid in EXEC)
//  rs_data              in   32  register-file read of rs (valid in EXEC)
//  jump_addr_selection  in   2   from branch_control: 00 none, 01 reg abs, 10 page abs, 11 pc rel
//  pc                   out  32  current instruction address (instruction memory address)
//  pc_plus8             out  32  pc+8, link value for JAL/JALR/BxxAL writeback
//  state                out  1   0 = FETCH, 1 = EXEC
//  active               out  1   high while running; low once halted
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - pc=RESET_VECTOR, state=FETCH, active=1
//   - all target capture registers cleared to 0
//  Sequencing, active=1 and stall=0:
//   - FETCH->EXEC every cycle; EXEC->FETCH every cycle
//   - one instruction per 2 cycles
//  stall=1:
//   - state, pc and capture registers hold
//   - stall has priority over every transition
//  Target capture, end of EXEC (state=1, stall=0):
//   - Captures only when jump_addr_selection==00, i.e. no jump is pending.
//   - A branch in a delay slot must not overwrite the pending target; delay-slot branches are undefined by ISA, target is held.
//   - reg_q <= rs_data
//   - page_q <= {pc_plus4[31:28], instruction_word[25:0], 2'b00}
//   - rel_q <= pc_plus4 + {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00}
//   - Arithmetic is 32-bit modulo 2^32; wrap-around is silently allowed.
//  PC update, end of EXEC (stall=0):
//   - jump_addr_selection selects next_pc:
//     00 -> pc+4; 01 -> reg_q; 10 -> page_q; 11 -> rel_q
//   - branch_control asserts jump_addr_selection only during the delay-slot instruction, so the jump lands after the delay slot.
//   - pc does not change in FETCH.
//  Halt:
//   - Triggered when an EXEC end loads next_pc==HALT_ADDR with selection!=00.
//   - active<=0 and pc<=HALT_ADDR; state returns to FETCH.
//   - Thereafter pc, state and captures are frozen until reset.
//   - Sequential pc+4 reaching HALT_ADDR (wrap) does NOT halt.
//  Misalignment:
//   - 01 target with [1:0]!=0 is loaded unchanged; no exception is generated.
//  Reset mid-operation:
//   - Async reset is immediate; any pending target is discarded.
//  Outputs:
//   - pc and state are registered.
//   - pc_plus8 is combinational, pc+8.
// STRUCTURE
//  Shared package cpu_pkg:
//   - typedef enum logic[1:0] jump_sel_t {JS_NONE, JS_REG, JS_PAGE, JS_REL}, also used by branch_control
//   - typedef enum logic cycle_state_t {FETCH, EXEC}
//   - RESET_VECTOR and HALT_ADDR localparams
//  Sub-module branch_target_gen (combinational):
//   - inputs pc_plus4, instruction_word
//   - outputs page and rel targets
//   - sequencer keeps the state/capture/PC registers
// TESTING
//  1 Reset release, no jumps, stall=0 -> pc 0xBFC00000, 0xBFC00004, 0xBFC00008 on successive EXEC ends; state toggles every cycle.
//  2 BEQ taken at 0xBFC00010, offset 0x0003: selection=11 during delay slot at 0xBFC00014 -> next pc 0xBFC00020.
//  3 JR: rs_data=0xBFC00100 at 0xBFC00020 -> delay slot 0xBFC00024 executes, then pc=0xBFC00100; rs_data changes in delay slot are ignored.
//  4 J instr_index=0x0000040 at 0xBFC00030 -> pc=0xB0000100 after delay slot.
//  5 JR to 0x0 -> delay slot completes, active falls, pc=0, then pc/state frozen for 20 cycles.
//  6 stall held 5 cycles mid-EXEC with pending JS_REL -> no state change; jump still lands correctly; reset_n pulse mid-delay-slot -> pc=RESET_VECTOR, target discarded.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and constants shared by the harvard CPU control path
// (sequencer and branch_control).
package cpu_pkg;

    typedef enum logic [1:0] {
        JS_NONE = 2'b00,
        JS_REG  = 2'b01,
        JS_PAGE = 2'b10,
        JS_REL  = 2'b11
    } jump_sel_t;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } cycle_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational page-absolute and pc-relative target computation
// for the instruction currently in EXEC.
module branch_target_gen (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instruction_word,
    output logic [31:0] page_target,
    output logic [31:0] rel_target
);

    logic unused_opcode;

    // The opcode field plays no part in target arithmetic.
    assign unused_opcode = ^instruction_word[31:26];

    assign page_target = {pc_plus4[31:28], instruction_word[25:0], 2'b00};
    assign rel_target  = pc_plus4 + {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and FETCH/EXEC sequencing; applies jumps selected by
// branch_control at the end of the delay-slot instruction.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = cpu_pkg::HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [31:0] instruction_word,
    input  logic [31:0] rs_data,
    input  logic [1:0]  jump_addr_selection,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        state,
    output logic        active
);

    import cpu_pkg::jump_sel_t;
    import cpu_pkg::cycle_state_t;
    import cpu_pkg::JS_NONE;
    import cpu_pkg::JS_REG;
    import cpu_pkg::JS_PAGE;
    import cpu_pkg::JS_REL;
    import cpu_pkg::FETCH;
    import cpu_pkg::EXEC;

    cycle_state_t state_reg;
    logic [31:0]  pc_reg;
    logic         active_reg;
    logic [31:0]  reg_tgt_reg;
    logic [31:0]  page_tgt_reg;
    logic [31:0]  rel_tgt_reg;

    jump_sel_t    sel;
    logic [31:0]  pc_plus4;
    logic [31:0]  page_target;
    logic [31:0]  rel_target;
    logic [31:0]  pc_next;

    assign sel      = jump_sel_t'(jump_addr_selection);
    assign pc_plus4 = pc_reg + 32'd4;
    assign pc_plus8 = pc_reg + 32'd8;
    assign pc       = pc_reg;
    assign state    = state_reg;
    assign active   = active_reg;

    branch_target_gen u_target_gen (
        .pc_plus4         (pc_plus4),
        .instruction_word (instruction_word),
        .page_target      (page_target),
        .rel_target       (rel_target)
    );

    // Jumps use the targets captured from the branch itself, one
    // instruction earlier, never the delay-slot instruction's fields.
    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            JS_NONE: pc_next = pc_plus4;
            JS_REG:  pc_next = reg_tgt_reg;
            JS_PAGE: pc_next = page_tgt_reg;
            JS_REL:  pc_next = rel_tgt_reg;
            default: pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_VECTOR;
            active_reg   <= 1'b1;
            reg_tgt_reg  <= 32'd0;
            page_tgt_reg <= 32'd0;
            rel_tgt_reg  <= 32'd0;
        end else if (active_reg && !stall) begin
            if (state_reg == FETCH) begin
                state_reg <= EXEC;
            end else begin
                state_reg <= FETCH;
                pc_reg    <= pc_next;
                if (sel == JS_NONE) begin
                    reg_tgt_reg  <= rs_data;
                    page_tgt_reg <= page_target;
                    rel_tgt_reg  <= rel_target;
                end else if (pc_next == HALT_ADDR) begin
                    // Only a taken jump halts; sequential wrap to HALT_ADDR does not.
                    active_reg <= 1'b0;
                end
            end
        end
    end

endmodule
